// File: rtl/ctrl_unit_pipe_if.sv
// -----------------------------------------------------------------------------
// ctrl_unit_pipe_if
//
// Purpose : bundles the decode inputs, pipeline-control inputs and all stage
//           control outputs of ctrl_unit_pipe into one interface.
//           clk and rst_n are not part of the bundle.
//
// Parameters
//   ALU_CTRL_W : ALU control width (4 = {funct7b5, funct3}, 3 = funct3 only)
//   REG_ADDR_W : register index width
//
// Signal summary
//   op_d, funct3_d, funct7b5_d   instruction fields in DECO
//   rs1_d, rs2_d, rd_d           register indices in DECO
//   freeze                       global pipeline hold
//   flush_e                      branch taken, resolved in EXE
//   sel_imm_d, illegal_d         combinational decode flags
//   hazard_stall                 hold PC / D register, bubble into E
//   *_e, *_m, *_w                per-stage control outputs
//   fwd_a_e, fwd_b_e             operand forwarding selects (00/10/01)
//
// Modports
//   master : instruction/datapath side (drives decode fields, freeze, flush)
//   slave  : the control unit itself
// -----------------------------------------------------------------------------
interface ctrl_unit_pipe_if #(
   parameter int ALU_CTRL_W = 4,
   parameter int REG_ADDR_W = 5
);

   // DECO inputs
   logic [6:0]            op_d;
   logic [2:0]            funct3_d;
   logic                  funct7b5_d;
   logic [REG_ADDR_W-1:0] rs1_d;
   logic [REG_ADDR_W-1:0] rs2_d;
   logic [REG_ADDR_W-1:0] rd_d;
   logic                  freeze;
   logic                  flush_e;

   // Combinational DECO outputs
   logic                  sel_imm_d;
   logic                  illegal_d;
   logic                  hazard_stall;

   // EXE outputs
   logic                  reg_write_e;
   logic                  alu_src_e;
   logic                  branch_e;
   logic [ALU_CTRL_W-1:0] alu_ctrl_e;
   logic [1:0]            mem_ctrl_e;
   logic [REG_ADDR_W-1:0] rd_e;
   logic [1:0]            fwd_a_e;
   logic [1:0]            fwd_b_e;

   // MEM outputs
   logic                  reg_write_m;
   logic [1:0]            mem_ctrl_m;
   logic [REG_ADDR_W-1:0] rd_m;

   // WB outputs
   logic                  reg_write_w;
   logic                  mem_to_reg_w;
   logic [REG_ADDR_W-1:0] rd_w;

   modport master (
      output op_d, funct3_d, funct7b5_d, rs1_d, rs2_d, rd_d, freeze, flush_e,
      input  sel_imm_d, illegal_d, hazard_stall,
      input  reg_write_e, alu_src_e, branch_e, alu_ctrl_e, mem_ctrl_e, rd_e,
      input  fwd_a_e, fwd_b_e,
      input  reg_write_m, mem_ctrl_m, rd_m,
      input  reg_write_w, mem_to_reg_w, rd_w
   );

   modport slave (
      input  op_d, funct3_d, funct7b5_d, rs1_d, rs2_d, rd_d, freeze, flush_e,
      output sel_imm_d, illegal_d, hazard_stall,
      output reg_write_e, alu_src_e, branch_e, alu_ctrl_e, mem_ctrl_e, rd_e,
      output fwd_a_e, fwd_b_e,
      output reg_write_m, mem_ctrl_m, rd_m,
      output reg_write_w, mem_to_reg_w, rd_w
   );

endinterface

// File: rtl/ctrl_unit_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_unit_pipe
//
// Purpose : pipelined RV32I control unit for a 5-stage core. Decodes the
//           opcode/funct fields in DECO and carries the control word through
//           the D->E, E->M and M->W registers. Detects load-use (and, without
//           forwarding, general RAW) hazards, inserts bubbles on stall or
//           branch flush, and honours a global freeze.
//
// Ports
//   clk    : core clock, rising edge
//   rst_n  : asynchronous active-low reset; all stages become bubbles
//   bus    : ctrl_unit_pipe_if.slave (decode fields, freeze/flush, all
//            stage control outputs)
//
// Parameters
//   ALU_CTRL_W : 4 -> {funct7b5, funct3}; 3 -> funct3 only
//   REG_ADDR_W : register index width (must match the interface instance)
//
// Build option
//   CTRL_FWD_EN : when defined, M/W forwarding selects are generated and only
//                 load-use stalls. When undefined, forwarding selects are 00
//                 and any RAW dependency on E or M stalls until the producer
//                 reaches W.
// -----------------------------------------------------------------------------
module ctrl_unit_pipe #(
   parameter int ALU_CTRL_W = 4,
   parameter int REG_ADDR_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   ctrl_unit_pipe_if.slave bus
);

   typedef enum logic [6:0] {
      OP_R      = 7'b0110011,
      OP_I_ALU  = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011
   } opcode_e;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_LOAD  = 2'b10;
   localparam logic [1:0] MEM_STORE = 2'b11;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_FROM_M  = 2'b10;
   localparam logic [1:0] FWD_FROM_W  = 2'b01;

   // Full control word held in the E register.
   typedef struct packed {
      logic                  reg_write;
      logic                  alu_src;
      logic                  branch;
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic [1:0]            mem_ctrl;
      logic                  mem_to_reg;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
   } ex_word_t;

   // Only the fields still consumed downstream travel past E.
   typedef struct packed {
      logic                  reg_write;
      logic [1:0]            mem_ctrl;
      logic                  mem_to_reg;
      logic [REG_ADDR_W-1:0] rd;
   } mem_word_t;

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [REG_ADDR_W-1:0] rd;
   } wb_word_t;

   ex_word_t  dec_word;
   ex_word_t  ex_d,  ex_q;
   mem_word_t mem_d, mem_q;
   wb_word_t  wb_d,  wb_q;

   logic [3:0] alu_full;
   logic       sel_imm;
   logic       illegal;
   logic       load_use;
   logic       hazard_stall;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   // A write in flight to a nonzero register that matches a source index.
   function automatic logic dep(input logic                  wr,
                                input logic [REG_ADDR_W-1:0] dst,
                                input logic [REG_ADDR_W-1:0] src);
      return wr && (dst != '0) && (dst == src);
   endfunction

   // ---------------------------------------------------------------------------
   // DECO: combinational decode of the instruction register fields
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      dec_word = '0;
      alu_full = '0;
      sel_imm  = 1'b0;
      illegal  = 1'b0;

      case (opcode_e'(bus.op_d))
         OP_R: begin
            dec_word.reg_write = 1'b1;
            alu_full           = {bus.funct7b5_d, bus.funct3_d};
         end
         OP_I_ALU: begin
            dec_word.reg_write = 1'b1;
            dec_word.alu_src   = 1'b1;
            // instr[30] is immediate data except for SRAI/SRLI.
            alu_full = {(bus.funct3_d == 3'b101) & bus.funct7b5_d, bus.funct3_d};
         end
         OP_LOAD: begin
            dec_word.reg_write  = 1'b1;
            dec_word.alu_src    = 1'b1;
            dec_word.mem_ctrl   = MEM_LOAD;
            dec_word.mem_to_reg = 1'b1;
         end
         OP_STORE: begin
            dec_word.alu_src  = 1'b1;
            dec_word.mem_ctrl = MEM_STORE;
            sel_imm           = 1'b1;
         end
         OP_BRANCH: begin
            dec_word.branch = 1'b1;
            alu_full        = {1'b0, bus.funct3_d};
         end
         default: illegal = 1'b1;
      endcase

      dec_word.alu_ctrl = alu_full[ALU_CTRL_W-1:0];

      // An illegal opcode leaves the whole word zero, i.e. a bubble.
      if (!illegal) begin
         dec_word.rd  = bus.rd_d;
         dec_word.rs1 = bus.rs1_d;
         dec_word.rs2 = bus.rs2_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Hazard detection and forwarding
   // ---------------------------------------------------------------------------
   always_comb begin
      load_use = (ex_q.mem_ctrl == MEM_LOAD) && (ex_q.rd != '0) &&
                 ((ex_q.rd == bus.rs1_d) || (ex_q.rd == bus.rs2_d));
   end

`ifdef CTRL_FWD_EN
   // Loaded data is only available after MEM, so load-use is the one case
   // forwarding cannot cover.
   always_comb begin
      hazard_stall = load_use;

      // The younger producer (M) wins over the older one (W).
      fwd_a = FWD_REGFILE;
      if (dep(mem_q.reg_write, mem_q.rd, ex_q.rs1))     fwd_a = FWD_FROM_M;
      else if (dep(wb_q.reg_write, wb_q.rd, ex_q.rs1))  fwd_a = FWD_FROM_W;

      fwd_b = FWD_REGFILE;
      if (dep(mem_q.reg_write, mem_q.rd, ex_q.rs2))     fwd_b = FWD_FROM_M;
      else if (dep(wb_q.reg_write, wb_q.rd, ex_q.rs2))  fwd_b = FWD_FROM_W;
   end
`else
   // Without forwarding the consumer waits in D until the producer is in W;
   // the register file is written in the first half of the cycle, so W needs
   // no stall.
   always_comb begin
      hazard_stall = load_use ||
                     dep(ex_q.reg_write,  ex_q.rd,  bus.rs1_d) ||
                     dep(ex_q.reg_write,  ex_q.rd,  bus.rs2_d) ||
                     dep(mem_q.reg_write, mem_q.rd, bus.rs1_d) ||
                     dep(mem_q.reg_write, mem_q.rd, bus.rs2_d);
      fwd_a = FWD_REGFILE;
      fwd_b = FWD_REGFILE;
   end

   // Source indices in E only feed forwarding, which is absent in this build.
   logic unused_rs_e;
   assign unused_rs_e = ^{ex_q.rs1, ex_q.rs2};
`endif

   // ---------------------------------------------------------------------------
   // Pipeline register next-state
   //   freeze         : everything holds (also swallows a same-cycle flush_e)
   //   flush / stall  : E takes a bubble, M and W still advance
   //   otherwise      : E takes the decoded word
   // ---------------------------------------------------------------------------
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;

      if (!bus.freeze) begin
         if (bus.flush_e || hazard_stall) ex_d = '0;
         else                             ex_d = dec_word;

         mem_d.reg_write  = ex_q.reg_write;
         mem_d.mem_ctrl   = ex_q.mem_ctrl;
         mem_d.mem_to_reg = ex_q.mem_to_reg;
         mem_d.rd         = ex_q.rd;

         wb_d.reg_write   = mem_q.reg_write;
         wb_d.mem_to_reg  = mem_q.mem_to_reg;
         wb_d.rd          = mem_q.rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: all pipeline fields are reset: these are a few control flops,
         // not a storage array, and every stage must come up as a known bubble.
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so each stage
         // samples the previous stage's old value in the same edge.
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.sel_imm_d    = sel_imm;
   assign bus.illegal_d    = illegal;
   assign bus.hazard_stall = hazard_stall;

   assign bus.reg_write_e  = ex_q.reg_write;
   assign bus.alu_src_e    = ex_q.alu_src;
   assign bus.branch_e     = ex_q.branch;
   assign bus.alu_ctrl_e   = ex_q.alu_ctrl;
   assign bus.mem_ctrl_e   = ex_q.mem_ctrl;
   assign bus.rd_e         = ex_q.rd;
   assign bus.fwd_a_e      = fwd_a;
   assign bus.fwd_b_e      = fwd_b;

   assign bus.reg_write_m  = mem_q.reg_write;
   assign bus.mem_ctrl_m   = mem_q.mem_ctrl;
   assign bus.rd_m         = mem_q.rd;

   assign bus.reg_write_w  = wb_q.reg_write;
   assign bus.mem_to_reg_w = wb_q.mem_to_reg;
   assign bus.rd_w         = wb_q.rd;

endmodule

// File: doc/ctrl_unit_pipe.md
Name: ctrl_unit_pipe

Overview:
- Parametrised successor to the single-cycle RV32I control decoder.
- Decodes op/funct in DECO and carries the control word through the D→E, E→M and M→W pipeline registers.
- Adds load support, a 4-bit ALU control that includes funct7[5], load-use hazard detection, bubble/flush insertion and a global freeze.
- Sits between the instruction register and the datapath stage muxes of the 5-stage core.

Parameters:
- ALU_CTRL_W, 4, width of the ALU control word. Value 4 gives {funct7b5, funct3}; value 3 gives funct3 only, with funct7b5 ignored.
- REG_ADDR_W, 5, register-index width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_d  in  7  opcode in DECO.
- funct3_d  in  3  funct3 in DECO.
- funct7b5_d  in  1  instr[30] in DECO.
- rs1_d, rs2_d, rd_d  in  REG_ADDR_W  register indices in DECO.
- freeze  in  1  global pipeline hold, e.g. memory wait.
- flush_e  in  1  branch taken, resolved in EXE.
- sel_imm_d  out  1  store-immediate format select (combinational).
- illegal_d  out  1  unsupported opcode in DECO (combinational).
- hazard_stall  out  1  hold PC and the D register; bubble into E (combinational).
- reg_write_e, alu_src_e, branch_e  out  1  EXE controls.
- alu_ctrl_e  out  ALU_CTRL_W  ALU operation.
- mem_ctrl_e, mem_ctrl_m  out  2  {enable, write}.
- rd_e, rd_m, rd_w  out  REG_ADDR_W  destination register per stage.
- reg_write_m, reg_write_w, mem_to_reg_w  out  1  later-stage controls.
- fwd_a_e, fwd_b_e  out  2  forwarding selects: 00 = regfile, 10 = from M, 01 = from W.

Behaviour:
- Decode is combinational on the D inputs:
  - R 0110011: reg_write=1.
  - I-ALU 0010011: reg_write=1, alu_src=1.
  - Load 0000011: reg_write=1, alu_src=1, mem=10, mem_to_reg=1.
  - Store 0100011: alu_src=1, mem=11, sel_imm=1.
  - Branch 1100011: branch=1.
  - Any other opcode: all controls 0, illegal_d=1.
- ALU control:
  - R-type: {funct7b5, funct3}.
  - I-ALU: {funct7b5 only when funct3==101, else 0, funct3}.
  - Load/store: forced to 0 (ADD).
  - Branch: {0, funct3}.
  - When ALU_CTRL_W=3, the MSB is dropped.
- Control word = {reg_write, alu_src, branch, alu_ctrl, mem_ctrl, mem_to_reg, rd, rs1, rs2}.
- Reset (rst_n=0, asynchronous): every registered output and every internal pipeline field is 0, so all stages hold bubbles. Outputs are valid from the first rising edge after deassertion.
- Latency: a decoded word appears on the *_e outputs 1 cycle after DECO, on *_m after 2 cycles, on *_w after 3 cycles.
- Load-use hazard:
  - Condition: mem_ctrl_e==10 and rd_e!=0 and (rd_e==rs1_d or rd_e==rs2_d).
  - Response: hazard_stall=1, same cycle.
- E register update priority:
  1. freeze=1: hold all stages.
  2. flush_e or hazard_stall: E loads a bubble (all zero).
  3. Otherwise E loads the decoded word.
- E→M and M→W shift every cycle unless freeze=1. flush_e does not affect M or W.
- freeze and flush_e in the same cycle: freeze wins, and flush_e must be re-presented by EXE.
- x0 (index 0) never raises a hazard or a forward.
- An illegal opcode enters E as a bubble: no write and no memory access.

Optional Feature:
- Macro: CTRL_FWD_EN.
- Defined:
  - fwd_a_e = 10 if reg_write_m and rd_m!=0 and rd_m==rs1_e.
  - Else fwd_a_e = 01 if reg_write_w and rd_w!=0 and rd_w==rs1_e.
  - Else fwd_a_e = 00.
  - fwd_b_e follows the same rule using rs2_e.
  - M takes priority over W.
  - Only load-use stalls.
- Undefined:
  - fwd_a_e and fwd_b_e are tied to 00.
  - hazard_stall additionally asserts when rs1_d or rs2_d (nonzero) matches rd_e with reg_write_e, or rd_m with reg_write_m.
  - The stall lasts until the producer reaches W.

Test Plan:
- Reset: drive rst_n=0 mid-stream with a valid word in E/M/W → all outputs 0 immediately, without waiting for a clock edge.
- Decode: sub x3,x1,x2 (op 0110011, f3 000, f7b5 1) → 1 cycle later reg_write_e=1, alu_ctrl_e=1000, rd_e=3; reg_write_w=1 two cycles after that.
- Load-use: lw x5 then add x6,x5,x1 → hazard_stall=1 for exactly 1 cycle; E shows a bubble; add reaches E the next cycle with fwd_a_e=01 (FWD_EN).
- Flush: beq in E with flush_e=1 → next-cycle E all 0; an in-flight store already in M still completes with mem_ctrl_m=11.
- Freeze: freeze=1 for 3 cycles during a store/add sequence → all *_e/*_m/*_w outputs constant; they resume shifting on release.
- Without CTRL_FWD_EN: add x1 followed by sub x2,x1,x1 → hazard_stall=1 for 2 cycles; fwd_a_e and fwd_b_e stay 00.
